// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, bubble encoding and fetch FSM states.
package mips_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    // sll $0,$0,0
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DISCARD
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ready handshake between the fetch stage (master) and imem (slave).
interface if_fetch_unit_if;
    import mips_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc_plus4} holding register that parks a returned word while ID is stalled.
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_unload,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc_plus4,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc_plus4,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_plus4;
    logic               r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_clear || i_unload) begin
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage and IF/ID register with stall/branch handling and a one-entry skid buffer.
// Optional stall-cycle counter is built only when FETCH_PERF_CNT_EN is defined.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_write,
    input  logic               if_id_write,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    if_fetch_unit_if.master    imem,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc_plus4,
    output logic               if_id_valid,
    output logic [31:0]        stall_cycles
);

    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_req;
    logic [ADDR_W-1:0]  r_addr;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_plus4;
    logic               r_valid;

    logic               w_stall;
    logic [ADDR_W-1:0]  w_pc_plus4;
    logic [ADDR_W-1:0]  w_branch_pc;
    logic               w_skid_load;
    logic               w_skid_unload;
    logic               w_skid_clear;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [ADDR_W-1:0]  w_skid_pc_plus4;
    logic               w_skid_valid;

    assign w_stall     = !(pc_write && if_id_write);
    assign w_pc_plus4  = r_pc + ADDR_W'(4);
    assign w_branch_pc = branch_target & ~ADDR_W'(3);

    assign w_skid_load   = (r_state == FETCH) && imem.imem_ready && !branch_taken && w_stall;
    assign w_skid_unload = (r_state == HOLD) && !branch_taken && !w_stall;
    assign w_skid_clear  = (r_state == HOLD) && branch_taken;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_skid_load),
        .i_unload   (w_skid_unload),
        .i_clear    (w_skid_clear),
        .i_instr    (imem.imem_rdata),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (w_skid_instr),
        .o_pc_plus4 (w_skid_pc_plus4),
        .o_valid    (w_skid_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (branch_taken) begin
                        r_instr    <= NOP_INSTR;
                        r_pc_plus4 <= '0;
                        r_valid    <= 1'b0;
                        r_pc       <= w_branch_pc;
                        // Data arriving with the redirect is dropped here, so no DISCARD trip.
                        if (imem.imem_ready) r_addr  <= w_branch_pc;
                        else                 r_state <= DISCARD;
                    end else if (imem.imem_ready) begin
                        if (!w_stall) begin
                            r_instr    <= imem.imem_rdata;
                            r_pc_plus4 <= w_pc_plus4;
                            r_valid    <= 1'b1;
                            r_pc       <= w_pc_plus4;
                            r_addr     <= w_pc_plus4;
                        end else begin
                            r_req   <= 1'b0;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        r_instr    <= NOP_INSTR;
                        r_pc_plus4 <= '0;
                        r_valid    <= 1'b0;
                        r_pc       <= w_branch_pc;
                        r_addr     <= w_branch_pc;
                        r_req      <= 1'b1;
                        r_state    <= FETCH;
                    end else if (!w_stall && w_skid_valid) begin
                        r_instr    <= w_skid_instr;
                        r_pc_plus4 <= w_skid_pc_plus4;
                        r_valid    <= 1'b1;
                        r_pc       <= w_pc_plus4;
                        r_addr     <= w_pc_plus4;
                        r_req      <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                DISCARD: begin
                    if (branch_taken) r_pc <= w_branch_pc;
                    if (imem.imem_ready) begin
                        r_addr  <= branch_taken ? w_branch_pc : r_pc;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == FETCH || r_state == HOLD) && w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = '0;
`endif

    assign imem.imem_req   = r_req;
    assign imem.imem_addr  = r_addr;
    assign if_id_instr     = r_instr;
    assign if_id_pc_plus4  = r_pc_plus4;
    assign if_id_valid     = r_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized self-checking bench for if_fetch_unit against a queue-based fetch reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        if_id_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] stall_cycles;

    logic [31:0] d2_instr;
    logic [31:0] d2_pc_plus4;
    logic        d2_valid;
    logic [31:0] d2_stall_cycles;

    if_fetch_unit_if imem ();
    if_fetch_unit_if imem2 ();

    assign imem2.imem_ready = 1'b1;
    assign imem2.imem_rdata = 32'hDEAD_0001;

    if_fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem           (imem.master),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .stall_cycles   (stall_cycles)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem           (imem2.master),
        .if_id_instr    (d2_instr),
        .if_id_pc_plus4 (d2_pc_plus4),
        .if_id_valid    (d2_valid),
        .stall_cycles   (d2_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an outstanding request, a discard flag and a skid queue.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } word_t;

    bit          m_started, m_req, m_disc, m_valid;
    logic [31:0] m_pc, m_addr, m_instr, m_pc4, m_cnt;
    word_t       m_skid[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_0005;
        if (a == 32'h4) return 32'h2002_0007;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic void model_reset();
        m_started = 1'b0;
        m_req     = 1'b0;
        m_disc    = 1'b0;
        m_pc      = 32'h0;
        m_addr    = 32'h0;
        m_instr   = NOP;
        m_pc4     = 32'h0;
        m_valid   = 1'b0;
        m_cnt     = 32'h0;
        m_skid.delete();
    endfunction

    function automatic void model_step(input bit pcw, input bit idw, input bit br,
                                       input logic [31:0] tgt, input bit rdy,
                                       input logic [31:0] rd);
        bit          stall   = !(pcw && idw);
        bit          got     = m_req && rdy;
        bit          holding = (m_skid.size() != 0);
        logic [31:0] tgt_a   = tgt & 32'hFFFF_FFFC;
        word_t       w;
        if (!m_started) begin
            m_started = 1'b1;
            m_req     = 1'b1;
            m_addr    = m_pc;
            return;
        end
`ifdef FETCH_PERF_CNT_EN
        if (!m_disc && stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
        if (br) begin
            m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
            m_pc = tgt_a;
            if (m_disc) begin
                if (got) begin m_disc = 1'b0; m_addr = tgt_a; end
            end else if (holding) begin
                m_skid.delete();
                m_req = 1'b1; m_addr = tgt_a;
            end else if (got) begin
                m_addr = tgt_a;
            end else begin
                m_disc = 1'b1;
            end
        end else if (m_disc) begin
            if (got) begin m_disc = 1'b0; m_addr = m_pc; end
        end else if (holding) begin
            if (!stall) begin
                w = m_skid.pop_front();
                m_instr = w.instr; m_pc4 = w.pc4; m_valid = 1'b1;
                m_pc = m_pc + 4; m_req = 1'b1; m_addr = m_pc;
            end
        end else if (got) begin
            if (!stall) begin
                m_instr = rd; m_pc4 = m_pc + 4; m_valid = 1'b1;
                m_pc = m_pc + 4; m_addr = m_pc;
            end else begin
                w.instr = rd; w.pc4 = m_pc + 4;
                m_skid.push_back(w);
                m_req = 1'b0;
            end
        end
    endfunction

    task automatic compare_all();
        check_eq("req",   {31'b0, imem.imem_req}, {31'b0, m_req});
        check_eq("addr",  imem.imem_addr, m_addr);
        check_eq("instr", if_id_instr, m_instr);
        check_eq("pc4",   if_id_pc_plus4, m_pc4);
        check_eq("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        check_eq("stall", stall_cycles, m_cnt);
    endtask

    task automatic cyc(input bit pcw, input bit idw, input bit br,
                       input logic [31:0] tgt, input bit rdy);
        logic [31:0] rd;
        @(negedge clk);
        rd = m_req ? mem_word(m_addr) : $urandom;
        pc_write          = pcw;
        if_id_write       = idw;
        branch_taken      = br;
        branch_target     = tgt;
        imem.imem_ready   = rdy;
        imem.imem_rdata   = rd;
        @(posedge clk);
        model_step(pcw, idw, br, tgt, rdy, rd);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        imem.imem_ready = 1'b1;
        imem.imem_rdata = $urandom;
        branch_taken    = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit          pcw, idw, br, rdy;
        logic [31:0] held_instr, held_pc4;

        rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
        branch_taken = 1'b0; branch_target = 32'h0;
        imem.imem_ready = 1'b0; imem.imem_rdata = 32'h0;
        model_reset();

        // Zero-wait fetch from reset, plus the wrapping instance.
        do_reset();
        check_eq("rst_req", {31'b0, imem.imem_req}, 32'h0);
        check_eq("rst_valid", {31'b0, if_id_valid}, 32'h0);
        cyc(1, 1, 0, 0, 1);
        check_eq("wrap_addr0", imem2.imem_addr, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0, 1);
        check_eq("t1_instr0", if_id_instr, 32'h2001_0005);
        check_eq("t1_pc4_0", if_id_pc_plus4, 32'h4);
        check_eq("wrap_addr1", imem2.imem_addr, 32'h0);
        check_eq("wrap_pc4", d2_pc_plus4, 32'h0);
        check_eq("wrap_instr", d2_instr, 32'hDEAD_0001);
        check_eq("wrap_valid", {31'b0, d2_valid}, 32'h1);
        check_eq("wrap_stall", d2_stall_cycles, 32'h0);
        cyc(1, 1, 0, 0, 1);
        check_eq("t1_instr1", if_id_instr, 32'h2002_0007);
        check_eq("t1_pc4_1", if_id_pc_plus4, 32'h8);
        check_eq("t1_valid", {31'b0, if_id_valid}, 32'h1);

        // Three-cycle stall with memory ready.
        held_instr = if_id_instr;
        held_pc4   = if_id_pc_plus4;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            check_eq("t2_hold_instr", if_id_instr, held_instr);
            check_eq("t2_hold_pc4", if_id_pc_plus4, held_pc4);
            check_eq("t2_req_low", {31'b0, imem.imem_req}, 32'h0);
        end
`ifdef FETCH_PERF_CNT_EN
        check_eq("t2_cnt", stall_cycles, 32'd3);
`else
        check_eq("t2_cnt", stall_cycles, 32'd0);
`endif
        cyc(1, 1, 0, 0, 1);
        check_eq("t2_release_pc4", if_id_pc_plus4, 32'hC);
        check_eq("t2_release_instr", if_id_instr, mem_word(32'h8));

        // Branch during a wait state at 0x10.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, (i != 0));
        check_eq("t3_addr10", imem.imem_addr, 32'h10);
        cyc(1, 1, 1, 32'h40, 0);
        check_eq("t3_flush_valid", {31'b0, if_id_valid}, 32'h0);
        check_eq("t3_addr_stable", imem.imem_addr, 32'h10);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        check_eq("t3_discard_valid", {31'b0, if_id_valid}, 32'h0);
        check_eq("t3_target_addr", imem.imem_addr, 32'h40);
        cyc(1, 1, 0, 0, 1);
        check_eq("t3_target_instr", if_id_instr, mem_word(32'h40));
        check_eq("t3_target_pc4", if_id_pc_plus4, 32'h44);

        // Branch while holding a skid word.
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 1, 32'h200, 0);
        check_eq("t4_nop", if_id_instr, NOP);
        check_eq("t4_valid", {31'b0, if_id_valid}, 32'h0);
        check_eq("t4_addr", imem.imem_addr, 32'h200);
        cyc(1, 1, 0, 0, 1);
        check_eq("t4_pc4", if_id_pc_plus4, 32'h204);

        // Unaligned target with same-cycle ready.
        cyc(1, 1, 1, 32'h43, 1);
        check_eq("t5_addr40", imem.imem_addr, 32'h40);
        check_eq("t5_req", {31'b0, imem.imem_req}, 32'h1);

        // Reset while a request is pending and memory answers.
        cyc(1, 1, 0, 0, 0);
        do_reset();
        check_eq("t6_addr", imem.imem_addr, 32'h0);
        check_eq("t6_instr", if_id_instr, NOP);
        cyc(1, 1, 0, 0, 0);
        check_eq("t6_restart", imem.imem_addr, 32'h0);
        check_eq("t6_valid", {31'b0, if_id_valid}, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                pcw = ($urandom_range(0, 7) != 0);
                idw = ($urandom_range(0, 7) != 0);
                br  = m_started && ($urandom_range(0, 11) == 0);
                rdy = ($urandom_range(0, 9) < 6);
                cyc(pcw, idw, br, $urandom, rdy);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
